act_buf_swap_ctrl: RTL and testbench

Double-buffer (ping-pong) controller for the MAC engine activation memory. Splits the 16 KiB activation SRAM into two 8 KiB buffers. A 32-bit external loader stream fills one buffer while the PE array computes out of the other. The block sits between the external write port, the activation SRAM write port and the engine control unit, and sequences the buffer hand-over with per-buffer state tracking.

---
 rtl/act_buf_swap_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_act_buf_swap_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_buf_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : act_buf_swap_ctrl
//  Purpose  : Ping-pong controller for the MAC engine activation SRAM. The
//             16 KiB memory is split into two 8 KiB buffers; the loader stream
//             fills one buffer while the PE array computes out of the other.
//             Each buffer walks EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i / rst_ni      : clock, synchronous active-low reset
//    ld_valid_i/ready_o  : loader word handshake
//    ld_data_i/last_i    : loader word and end-of-image marker
//    mem_we_o/addr_o/    : registered SRAM write port (byte address,
//    mem_wdata_o           word aligned, one cycle after the handshake)
//    cmp_req_i           : compute side asks for a filled buffer (level)
//    cmp_grant_o         : one-cycle grant pulse
//    cmp_base_o          : base byte address of the granted buffer
//    cmp_done_i          : compute side releases its buffer (pulse)
//    buf_full_o          : bit b set while buffer b is FULL or BUSY
//    err_overflow_o      : sticky image-overflow flag, err_clr_i clears
//    stall_cnt_o         : compute stall cycle counter
//  Build option
//    ACT_BUF_STALL_CNT_EN : when defined, stall_cnt_o counts cycles with a
//                           pending request and no grant (saturating);
//                           otherwise it is tied to zero.
// ============================================================================
module act_buf_swap_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int PORT_W    = 32,
  parameter int BUF_BYTES = 8192
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [PORT_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PORT_W-1:0] mem_wdata_o,
  input  logic              cmp_req_i,
  output logic              cmp_grant_o,
  output logic [ADDR_W-1:0] cmp_base_o,
  input  logic              cmp_done_i,
  output logic [1:0]        buf_full_o,
  output logic              err_overflow_o,
  input  logic              err_clr_i,
  output logic [31:0]       stall_cnt_o
);

  // Byte shift of one port word and width of the per-buffer word counter.
  localparam int                c_byte_sh   = $clog2(PORT_W / 8);
  localparam int                c_cnt_w     = $clog2(BUF_BYTES) - c_byte_sh;
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;
  localparam logic [ADDR_W-1:0] c_buf1_base = ADDR_W'(BUF_BYTES);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2,
    S_BUSY    = 2'd3
  } buf_state_t;

  buf_state_t          r_buf_state [2];
  logic                r_fill_sel;
  logic                r_cmp_sel;
  logic [c_cnt_w-1:0]  r_word_cnt;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [PORT_W-1:0]   r_mem_wdata;
  logic                r_cmp_grant;
  logic [ADDR_W-1:0]   r_cmp_base;
  logic                r_err_overflow;

  logic                w_ld_ready;
  logic                w_hs;
  logic                w_cnt_wrap;
  logic                w_img_end;
  logic                w_overflow;
  logic                w_any_busy;
  logic                w_grant;
  logic                w_done;
  logic [ADDR_W-1:0]   w_word_off;
  logic [ADDR_W-1:0]   w_wr_addr;

  // Ready depends only on registered buffer state, never on ld_valid_i.
  assign w_ld_ready = (r_buf_state[r_fill_sel] == S_EMPTY) ||
                      (r_buf_state[r_fill_sel] == S_FILLING);
  assign w_hs       = ld_valid_i & w_ld_ready;

  // A full-length image without last is force-closed and flagged.
  assign w_cnt_wrap = (r_word_cnt == c_cnt_max);
  assign w_img_end  = w_hs & (ld_last_i | w_cnt_wrap);
  assign w_overflow = w_hs & w_cnt_wrap & ~ld_last_i;

  assign w_any_busy = (r_buf_state[0] == S_BUSY) || (r_buf_state[1] == S_BUSY);

  // Only one buffer can be BUSY and it is always the one cmp_sel points at,
  // so grant and done are mutually exclusive and both act on r_cmp_sel.
  // The loader can only act on an EMPTY/FILLING buffer, so it never collides
  // with a grant or done on the same buffer.
  assign w_grant = cmp_req_i & (r_buf_state[r_cmp_sel] == S_FULL) & ~w_any_busy;
  assign w_done  = cmp_done_i & (r_buf_state[r_cmp_sel] == S_BUSY);

  assign w_word_off = ADDR_W'(r_word_cnt) << c_byte_sh;
  assign w_wr_addr  = (r_fill_sel ? c_buf1_base : '0) + w_word_off;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_buf_state[0] <= S_EMPTY;
      r_buf_state[1] <= S_EMPTY;
      r_fill_sel     <= 1'b0;
      r_cmp_sel      <= 1'b0;
      r_word_cnt     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cmp_grant    <= 1'b0;
      r_cmp_base     <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      // SRAM write port: one-cycle registered copy of the handshake.
      r_mem_we <= w_hs;
      if (w_hs) begin
        r_mem_addr  <= w_wr_addr;
        r_mem_wdata <= ld_data_i;
      end

      // Loader side of the fill buffer.
      if (w_hs) begin
        if (w_img_end) begin
          r_buf_state[r_fill_sel] <= S_FULL;
          r_word_cnt              <= '0;
          r_fill_sel              <= ~r_fill_sel;
        end else begin
          r_buf_state[r_fill_sel] <= S_FILLING;
          r_word_cnt              <= r_word_cnt + c_cnt_w'(1);
        end
      end

      // Compute side of the compute buffer.
      r_cmp_grant <= w_grant;
      if (w_grant) begin
        r_buf_state[r_cmp_sel] <= S_BUSY;
        r_cmp_base             <= r_cmp_sel ? c_buf1_base : '0;
      end
      if (w_done) begin
        r_buf_state[r_cmp_sel] <= S_EMPTY;
        r_cmp_sel              <= ~r_cmp_sel;
      end

      // Set wins over a same-cycle clear.
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end else if (err_clr_i) begin
        r_err_overflow <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf_full
    assign buf_full_o[b] = (r_buf_state[b] == S_FULL) || (r_buf_state[b] == S_BUSY);
  end

`ifdef ACT_BUF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts cycles where a request is pending but no grant is on the output.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (cmp_req_i && !r_cmp_grant && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  assign ld_ready_o     = w_ld_ready;
  assign mem_we_o       = r_mem_we;
  assign mem_addr_o     = r_mem_addr;
  assign mem_wdata_o    = r_mem_wdata;
  assign cmp_grant_o    = r_cmp_grant;
  assign cmp_base_o     = r_cmp_base;
  assign err_overflow_o = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_act_buf_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_act_buf_swap_ctrl
//  Purpose  : Self-checking bench for act_buf_swap_ctrl (directed scenarios
//             plus randomized traffic against a behavioural model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_act_buf_swap_ctrl;

  localparam int ADDR_W    = 14;
  localparam int PORT_W    = 32;
  localparam int BUF_BYTES = 8192;
`ifdef ACT_BUF_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam logic [97:0] RESET_VEC = {1'b1, 97'd0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [PORT_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PORT_W-1:0] mem_wdata;
  logic              cmp_req = 1'b0;
  logic              cmp_grant;
  logic [ADDR_W-1:0] cmp_base;
  logic              cmp_done = 1'b0;
  logic [1:0]        buf_full;
  logic              err_overflow;
  logic              err_clr = 1'b0;
  logic [31:0]       stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  act_buf_swap_ctrl #(
    .ADDR_W    (ADDR_W),
    .PORT_W    (PORT_W),
    .BUF_BYTES (BUF_BYTES)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ld_valid_i     (ld_valid),
    .ld_ready_o     (ld_ready),
    .ld_data_i      (ld_data),
    .ld_last_i      (ld_last),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .cmp_req_i      (cmp_req),
    .cmp_grant_o    (cmp_grant),
    .cmp_base_o     (cmp_base),
    .cmp_done_i     (cmp_done),
    .buf_full_o     (buf_full),
    .err_overflow_o (err_overflow),
    .err_clr_i      (err_clr),
    .stall_cnt_o    (stall_cnt)
  );

  // Behavioural model: per-buffer "image complete" and "in use by compute"
  // flags, the two pointers and the word index of the image being loaded.
  bit                m_full [2];
  bit                m_busy [2];
  int                m_fp, m_cp, m_n;
  logic              e_ready, e_we, e_grant, e_err;
  logic [ADDR_W-1:0] e_addr, e_base;
  logic [PORT_W-1:0] e_wdata;
  logic [1:0]        e_full;
  logic [31:0]       e_stall;

  logic [97:0] dut_vec, exp_vec;
  assign dut_vec = {ld_ready, mem_we, mem_addr, mem_wdata, cmp_grant, cmp_base,
                    buf_full, err_overflow, stall_cnt};
  assign exp_vec = {e_ready, e_we, e_addr, e_wdata, e_grant, e_base,
                    e_full, e_err, e_stall};

  task automatic model_reset();
    m_full = '{0, 0};
    m_busy = '{0, 0};
    m_fp = 0; m_cp = 0; m_n = 0;
    e_ready = 1'b1; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_grant = 1'b0; e_base = '0; e_full = 2'b00; e_err = 1'b0; e_stall = '0;
  endtask

  task automatic model_step();
    bit rdy, hs, img_end, ovf, grant, done;
    rdy   = !m_full[m_fp] && !m_busy[m_fp];
    hs    = ld_valid && rdy;
    grant = cmp_req && m_full[m_cp] && !(m_busy[0] || m_busy[1]);
    done  = cmp_done && (m_busy[0] || m_busy[1]);
    if (STALL_EN && cmp_req && !e_grant && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 1;
    e_we = hs;
    if (hs) begin
      e_addr  = ADDR_W'(m_fp * BUF_BYTES + 4 * m_n);
      e_wdata = ld_data;
    end
    ovf     = hs && (m_n == 2047) && !ld_last;
    img_end = hs && (ld_last || m_n == 2047);
    if (img_end) begin
      m_full[m_fp] = 1; m_fp = 1 - m_fp; m_n = 0;
    end else if (hs) begin
      m_n = m_n + 1;
    end
    e_grant = grant;
    if (grant) begin
      m_full[m_cp] = 0; m_busy[m_cp] = 1;
      e_base = ADDR_W'(m_cp * BUF_BYTES);
    end
    if (done) begin
      m_busy[m_cp] = 0; m_cp = 1 - m_cp;
    end
    if (ovf) e_err = 1'b1;
    else if (err_clr) e_err = 1'b0;
    e_ready = !m_full[m_fp] && !m_busy[m_fp];
    e_full  = {m_full[1] | m_busy[1], m_full[0] | m_busy[0]};
  endtask

  // One clock cycle with the currently driven inputs; outputs settle by #1.
  task automatic tick();
    if (!rst_n) model_reset();
    else        model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    cmp_req = 1'b0; cmp_done = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic load_words(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      ld_valid = 1'b1; ld_last = (i == cnt - 1); ld_data = $urandom;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b1; cmp_req = 1'b1; err_clr = 1'b1; ld_data = 32'hDEAD_BEEF;
    tick(); tick();
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, RESET_VEC);
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", ld_ready);
    end
    rst_n = 1'b1; ld_valid = 1'b0; cmp_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_fill16();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_last = (i == 15); ld_data = $urandom; d = ld_data;
      tick();
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(4 * i) || mem_wdata !== d) begin
        n_fail++;
        $display("FAIL fill16_write[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, ADDR_W'(4 * i), d);
      end
      n_checks++;
      if (ld_ready !== 1'b1 || buf_full !== ((i == 15) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL fill16_state[%0d]: got ready=%b full=%b expected ready=1 full=%b",
                 i, ld_ready, buf_full, (i == 15) ? 2'b01 : 2'b00);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL fill16_we_drop: got %b expected 0", mem_we);
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    load_words(4);
    cmp_req = 1'b1; ld_valid = 1'b1; ld_data = $urandom;
    tick();
    cmp_req = 1'b0;
    n_checks++;
    if (cmp_grant !== 1'b1 || cmp_base !== 14'h0000 || mem_we !== 1'b1 || mem_addr !== 14'h2000) begin
      n_fail++;
      $display("FAIL pingpong_grant0: got grant=%b base=%h we=%b addr=%h expected 1 0000 1 2000",
               cmp_grant, cmp_base, mem_we, mem_addr);
    end
    for (int i = 1; i < 4; i++) begin
      ld_last = (i == 3); ld_data = $urandom;
      tick();
      n_checks++;
      if (cmp_grant !== 1'b0 || cmp_base !== 14'h0000 || mem_addr !== ADDR_W'(14'h2000 + 4 * i)) begin
        n_fail++;
        $display("FAIL pingpong_fill1[%0d]: got grant=%b base=%h addr=%h expected 0 0000 %h",
                 i, cmp_grant, cmp_base, mem_addr, ADDR_W'(14'h2000 + 4 * i));
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_checks++;
    if (buf_full !== 2'b11) begin
      n_fail++; $display("FAIL pingpong_both_full: got %b expected 11", buf_full);
    end
    cmp_done = 1'b1; tick(); cmp_done = 1'b0;
    n_checks++;
    if (buf_full !== 2'b10) begin
      n_fail++; $display("FAIL pingpong_done0: got %b expected 10", buf_full);
    end
    cmp_req = 1'b1; tick(); cmp_req = 1'b0;
    n_checks++;
    if (cmp_grant !== 1'b1 || cmp_base !== 14'h2000) begin
      n_fail++; $display("FAIL pingpong_grant1: got grant=%b base=%h expected 1 2000", cmp_grant, cmp_base);
    end
    tick();
    n_checks++;
    if (cmp_grant !== 1'b0 || cmp_base !== 14'h2000 || dut_vec !== exp_vec) begin
      n_fail++; $display("FAIL pingpong_hold: got grant=%b base=%h vec=%h expected 0 2000 vec=%h",
                         cmp_grant, cmp_base, dut_vec, exp_vec);
    end
  endtask

  task automatic test_full_block();
    do_reset();
    load_words(4);
    load_words(4);
    ld_valid = 1'b1; ld_data = $urandom;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL block_held[%0d]: got ready=%b we=%b expected 0 0", k, ld_ready, mem_we);
      end
    end
    cmp_req = 1'b1; tick(); cmp_req = 1'b0;
    cmp_done = 1'b1; tick(); cmp_done = 1'b0;
    n_checks++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL block_release: got ready=%b we=%b expected 1 0", ld_ready, mem_we);
    end
    tick();
    ld_valid = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 14'h0000 || dut_vec !== exp_vec) begin
      n_fail++; $display("FAIL block_resume: got we=%b addr=%h vec=%h expected 1 0000 vec=%h",
                         mem_we, mem_addr, dut_vec, exp_vec);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ld_data = $urandom;
      tick();
      if (i == 2046) begin
        n_checks++;
        if (err_overflow !== 1'b0 || buf_full !== 2'b00) begin
          n_fail++; $display("FAIL ovf_early: got err=%b full=%b expected 0 00", err_overflow, buf_full);
        end
      end
    end
    ld_valid = 1'b0;
    n_checks++;
    if (mem_addr !== 14'h1FFC || mem_we !== 1'b1 || err_overflow !== 1'b1 ||
        buf_full !== 2'b01 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got addr=%h we=%b err=%b full=%b ready=%b expected 1ffc 1 1 01 1",
               mem_addr, mem_we, err_overflow, buf_full, ld_ready);
    end
    tick(); tick();
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected 1", err_overflow);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b expected 0", err_overflow);
    end
    ld_valid = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      err_clr = (i == 2047); ld_data = $urandom;
      tick();
    end
    ld_valid = 1'b0; err_clr = 1'b0;
    n_checks++;
    if (err_overflow !== 1'b1 || mem_addr !== 14'h3FFC || buf_full !== 2'b11) begin
      n_fail++; $display("FAIL ovf_set_vs_clear: got err=%b addr=%h full=%b expected 1 3ffc 11",
                         err_overflow, mem_addr, buf_full);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    load_words(3);
    cmp_req = 1'b1; tick(); cmp_req = 1'b0;
    load_words(2);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = $urandom; cmp_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; cmp_done = 1'b0;
    n_checks++;
    if (buf_full !== 2'b10 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_state: got full=%b ready=%b expected 10 1", buf_full, ld_ready);
    end
    ld_valid = 1'b1; cmp_req = 1'b1; ld_data = $urandom;
    tick();
    ld_valid = 1'b0; cmp_req = 1'b0;
    n_checks++;
    if (cmp_grant !== 1'b1 || cmp_base !== 14'h2000 || mem_we !== 1'b1 || mem_addr !== 14'h0000) begin
      n_fail++; $display("FAIL same_cycle_ptrs: got grant=%b base=%h we=%b addr=%h expected 1 2000 1 0000",
                         cmp_grant, cmp_base, mem_we, mem_addr);
    end
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    cmp_req = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    cmp_req = 1'b0;
    n_checks++;
    if (stall_cnt !== (STALL_EN ? 32'd5 : 32'd0)) begin
      n_fail++; $display("FAIL stall_count: got %0d expected %0d", stall_cnt, STALL_EN ? 5 : 0);
    end
    load_words(3);
    ld_valid = 1'b1; ld_data = $urandom;
    tick();
    rst_n = 1'b0; ld_data = $urandom;
    tick();
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL midfill_reset: got %h expected %h", dut_vec, RESET_VEC);
    end
    rst_n = 1'b1; ld_valid = 1'b0;
    tick();
    n_checks++;
    if (dut_vec !== RESET_VEC) begin
      n_fail++; $display("FAIL midfill_reset_idle: got %h expected %h", dut_vec, RESET_VEC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 799) != 0);
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_last  = ($urandom_range(0, 15) == 0);
      ld_data  = $urandom;
      cmp_req  = ($urandom_range(0, 2) != 0);
      cmp_done = ($urandom_range(0, 5) == 0);
      err_clr  = ($urandom_range(0, 49) == 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", c, dut_vec, exp_vec);
      end
    end
    rst_n = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; cmp_req = 1'b0; cmp_done = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill16();
    test_ping_pong();
    test_full_block();
    test_overflow();
    test_same_cycle();
    test_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
